vga_fb_fetcher: RTL and testbench
=================================

# vga_fb_fetcher

Framebuffer scan-out stage between the data memory's read-only port 1 and the final VGA RGB outputs. Once per displayed source row, during horizontal blanking, it prefetches 20 words of a 160x120, 4-bit-per-pixel framebuffer into an internal line buffer. During active video it expands each nibble through a fixed 16-colour palette into 8-bit R/G/B, scaled 4x in both axes to 640x480. The ARM program draws by storing into the framebuffer region of dmem; this block only reads.

## Interface
- FB_BASE, 32'h0000_0100: byte address of framebuffer word 0 (word-aligned).
- clk  input  1  pixel clock (the PLL vgaclk); the only clock.
- reset  input  1  asynchronous, active-low reset.
- x  input  10  current pixel column from the VGA controller, 0..799.
- y  input  10  current line from the VGA controller, 0..524.
- fb_en  input  1  1 = display the framebuffer; 0 = force black output and suppress fetches.
- mem_addr  output  32  byte address to dmem addr1.
- mem_rdata  input  32  dmem rd1; the word for mem_addr is valid one cycle after mem_addr is driven.
- r, g, b  output  8 each  registered pixel colour.
- fetch_busy  output  1  high while a row fetch is in progress.

## Operation
- Framebuffer layout: row R (0..119) occupies 20 words at FB_BASE + R*80 + W*4, W = 0..19; word W holds source pixels 8W..8W+7, pixel 8W+k in bits [4k+3:4k].
- Line buffer: 20 x 32-bit registers, all zero after reset.
- Fetch trigger, evaluated only at x == 640: next_y = (y == 524) ? 0 : y+1. A fetch starts iff fb_en == 1, next_y < 480 and next_y[1:0] == 0. Source row = next_y >> 2. Otherwise the buffer is kept, so every source row is displayed on 4 consecutive lines.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE: mem_addr = FB_BASE, fetch_busy = 0. On a trigger, go to ISSUE with word counter = 0.
  - ISSUE: drive mem_addr = FB_BASE + row*80 + cnt*4 and increment cnt. From the second ISSUE cycle on, capture mem_rdata into buffer[cnt-1]. Leave for DRAIN after issuing W = 19.
  - DRAIN: capture word 19, then return to IDLE.
- Row multiply uses no multiplier: row*80 = (row<<6) + (row<<4). Arithmetic is 32-bit.
- Pixel path: for x < 640 and y < 480, word = buffer[x>>5], nibble = word[4*((x>>2)&7) +: 4] = idx.
- Palette: r = idx[2] ? (idx[3] ? FF : AA) : (idx[3] ? 55 : 00); g uses idx[1] in the same way; b uses idx[0]. Example: idx 0 = black, F = white, 4 = AA/00/00, 8 = 55/55/55.
- Outside the active area, or with fb_en == 0: r = g = b = 0.
- fb_en deasserted mid-fetch: the fetch runs to completion. The flag gates only new triggers and the output.
- Reset (reset == 0), at any time including mid-fetch:
  - FSM goes to IDLE; mem_addr = FB_BASE, fetch_busy = 0, r/g/b = 0.
  - Line buffer is cleared.
  - After release, the first trigger rebuilds a correct row.

## Timing
- A fetch takes 21 cycles: ISSUE at x = 641..660, DRAIN at x = 661, fetch_busy high at x = 641..661. It completes well within the 160-cycle blank, and the buffer is stable before x wraps to 0.
- Pixel latency is 1 cycle: r/g/b in cycle n+1 reflect x,y of cycle n. The top level delays hsync, vsync and blank_b by one register to stay aligned.
- No trigger can occur while busy, because x == 640 recurs only 800 cycles later.

## Test plan
- Reset: hold reset = 0 with random x/y. Then r = g = b = 0, fetch_busy = 0, mem_addr = 32'h100. Release, and outputs stay 0 until the first fetch.
- Row-0 fetch: framebuffer word W = 32'h7654_3210 + W. Sweep y = 524 across x = 640..661.
  - mem_addr must run 100, 104, ..., 14C on x = 641..660.
  - fetch_busy must be high for 21 cycles.
- Pixel decode: on line 0 after the row-0 fetch:
  - x = 0..3 gives black.
  - x = 4..7 (idx 1) gives 00/00/AA one cycle later.
  - x = 28..31 (idx 7) gives AA/AA/AA.
  - x = 32 reads word 1.
- Row reuse: lines y = 0..2 at x = 640 issue no fetch (mem_addr stays 100). At y = 3, x = 640 a fetch starts with first address 0x150 (row 1).
- Boundary: y = 479 at x = 640 gives no fetch. With x >= 640 or y >= 480, RGB must be 0. With fb_en = 0, RGB is 0 and no fetch occurs at y = 524.
- Mid-fetch reset: assert reset at x = 650. Then mem_addr = 100 and the buffer reads as all zeros (black). The next valid trigger fetches the full row correctly.

Source files
------------

// File: rtl/vga_fb_fetcher.sv
// vga_fb_fetcher: prefetches one 160-pixel, 4 bpp framebuffer row per
// displayed source row during horizontal blanking, then expands each nibble
// through a fixed 16-colour palette into registered 8-bit R/G/B.
// Pixels are scaled 4x in both axes to fill 640x480.
module vga_fb_fetcher (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        fb_en,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        fetch_busy
);

  localparam logic [31:0] FB_BASE = 32'h0000_0100;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_cnt;
  logic [4:0]  w_cnt_nxt;
  logic [6:0]  r_row;
  logic [6:0]  w_row_nxt;
  logic        w_cap_en;
  logic [4:0]  w_cap_idx;
  logic [31:0] r_buf [0:19];

  logic [9:0]  w_next_y;
  logic        w_trigger;
  logic [31:0] w_row_off;
  logic        w_active;
  logic [31:0] w_word;
  logic [3:0]  w_idx;

  // One palette channel: the intensity bit plus the shared bright bit (idx[3]).
  function automatic logic [7:0] chan_level(input logic i_bright, input logic i_bit);
    logic [7:0] v;
    case ({i_bright, i_bit})
      2'b00:   v = 8'h00;
      2'b01:   v = 8'hAA;
      2'b10:   v = 8'h55;
      2'b11:   v = 8'hFF;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // Fetch trigger: the upcoming line starts a new source row (every 4th visible line).
  assign w_next_y  = (y == 10'd524) ? 10'd0 : (y + 10'd1);
  assign w_trigger = (x == 10'd640) && fb_en && (w_next_y < 10'd480) &&
                     (w_next_y[1:0] == 2'b00);

  // row*80 built from shifts; a row is 20 words = 80 bytes.
  assign w_row_off = ({25'd0, r_row} << 6) + ({25'd0, r_row} << 4);

  // Address and busy are pure decodes of registered state.
  assign mem_addr   = (r_state == S_ISSUE) ? (FB_BASE + w_row_off + {25'd0, r_cnt, 2'b00})
                                           : FB_BASE;
  assign fetch_busy = (r_state != S_IDLE);

  // FSM state, word counter and latched source row.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
      r_row   <= 7'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_row   <= w_row_nxt;
    end
  end

  // Next-state logic; read data lags the address by one cycle, so capture uses cnt-1.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_row_nxt   = r_row;
    w_cap_en    = 1'b0;
    w_cap_idx   = 5'd0;
    case (r_state)
      S_IDLE: begin
        if (w_trigger) begin
          w_state_nxt = S_ISSUE;
          w_cnt_nxt   = 5'd0;
          w_row_nxt   = w_next_y[8:2];
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        w_cnt_nxt = r_cnt + 5'd1;
        if (r_cnt != 5'd0) begin
          w_cap_en  = 1'b1;
          w_cap_idx = r_cnt - 5'd1;
        end else begin
          w_cap_en  = 1'b0;
        end
        if (r_cnt == 5'd19) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_DRAIN: begin
        w_cap_en    = 1'b1;
        w_cap_idx   = 5'd19;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Line buffer: cleared on reset, loaded one word per cycle during a fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 20; i++) begin
        r_buf[i] <= 32'd0;
      end
    end else if (w_cap_en) begin
      r_buf[w_cap_idx] <= mem_rdata;
    end
  end

  // Pixel lookup: 32 screen columns per word, 4 screen columns per nibble.
  always_comb begin
    w_active = fb_en && (x < 10'd640) && (y < 10'd480);
    w_word   = 32'd0;
    w_idx    = 4'd0;
    if (w_active) begin
      w_word = r_buf[x[9:5]];
      w_idx  = w_word[{x[4:2], 2'b00} +: 4];
    end else begin
      w_word = 32'd0;
      w_idx  = 4'd0;
    end
  end

  // Registered colour output, black outside the active area or when disabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r <= 8'h00;
      g <= 8'h00;
      b <= 8'h00;
    end else if (w_active) begin
      r <= chan_level(w_idx[3], w_idx[2]);
      g <= chan_level(w_idx[3], w_idx[1]);
      b <= chan_level(w_idx[3], w_idx[0]);
    end else begin
      r <= 8'h00;
      g <= 8'h00;
      b <= 8'h00;
    end
  end

endmodule

// File: tb/tb_vga_fb_fetcher.sv
// Directed bench for vga_fb_fetcher with a memory model and an RGB scoreboard.
module tb_vga_fb_fetcher;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        fb_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic [7:0]  r;
  logic [7:0]  g;
  logic [7:0]  b;
  logic        fetch_busy;

  int checks = 0;
  int errors = 0;

  logic [23:0] sb [$];
  logic [31:0] exp_buf [20];

  vga_fb_fetcher dut (
    .clk        (clk),
    .reset      (reset),
    .x          (x),
    .y          (y),
    .fb_en      (fb_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .r          (r),
    .g          (g),
    .b          (b),
    .fetch_busy (fetch_busy)
  );

  always #5 clk = ~clk;

  // Framebuffer contents: row R word W = 7654_3210 + W + (R << 24).
  function automatic logic [31:0] fb_word(input logic [31:0] addr);
    logic [31:0] idx;
    idx = (addr - 32'h100) >> 2;
    return 32'h7654_3210 + (idx % 32'd20) + ((idx / 32'd20) << 24);
  endfunction

  // dmem read port: data for an address appears one cycle later.
  always @(posedge clk) mem_rdata <= fb_word(mem_addr);

  function automatic logic [7:0] lvl(input logic hi, input logic lo);
    return hi ? (lo ? 8'hFF : 8'h55) : (lo ? 8'hAA : 8'h00);
  endfunction

  function automatic logic [23:0] model_rgb(input logic [9:0] px, input logic [9:0] py,
                                            input logic en);
    logic [31:0] w;
    logic [3:0]  idx;
    int          sh;
    if (!en || px >= 10'd640 || py >= 10'd480) return 24'h0;
    w   = exp_buf[int'(px) / 32];
    sh  = 4 * ((int'(px) / 4) % 8);
    idx = w[sh +: 4];
    return {lvl(idx[3], idx[2]), lvl(idx[3], idx[1]), lvl(idx[3], idx[0])};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One pixel clock: check the RGB produced from last cycle's inputs, then drive new ones.
  task automatic cyc(input logic [9:0] nx, input logic [9:0] ny, input logic en);
    logic [23:0] e;
    logic [9:0]  ny2;
    @(posedge clk); #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rgb", {8'h00, r, g, b}, {8'h00, e});
    end
    x = nx; y = ny; fb_en = en;
    sb.push_back(model_rgb(nx, ny, en));
    if (nx == 10'd640) begin
      ny2 = (ny == 10'd524) ? 10'd0 : ny + 10'd1;
      if (en && ny2 < 10'd480 && ny2[1:0] == 2'b00) begin
        for (int w = 0; w < 20; w++)
          exp_buf[w] = fb_word(32'h100 + 32'(ny2 / 10'd4) * 32'd80 + 32'(w) * 32'd4);
      end
    end
  endtask

  task automatic pixels(input logic [9:0] ly, input int x0, input int x1, input logic en);
    for (int i = x0; i <= x1; i++) cyc(10'(i), ly, en);
  endtask

  // Walk the blank from x=640 to last_x on line ly, checking address and busy.
  task automatic sweep(input logic [9:0] ly, input int last_x, input logic en,
                       input bit exp_fetch, input logic [31:0] exp_first);
    for (int i = 640; i <= last_x; i++) begin
      cyc(10'(i), ly, en);
      if (exp_fetch && i >= 641 && i <= 660)
        chk("addr", mem_addr, exp_first + 32'(i - 641) * 32'd4);
      else if (!(exp_fetch && i == 661))
        chk("addr", mem_addr, 32'h100);
      chk("busy", {31'd0, fetch_busy}, {31'd0, (exp_fetch && i >= 641 && i <= 661)});
    end
  endtask

  // Reset within the current cycle, hold for 3 edges with random x/y, then release.
  task automatic do_reset();
    #2;
    sb.delete();
    reset = 1'b0;
    for (int w = 0; w < 20; w++) exp_buf[w] = 32'd0;
    #1;
    chk("rst_rgb", {8'h00, r, g, b}, 32'd0);
    chk("rst_addr", mem_addr, 32'h100);
    chk("rst_busy", {31'd0, fetch_busy}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      x = 10'($urandom_range(799, 0));
      y = 10'($urandom_range(524, 0));
      chk("rst_rgb", {8'h00, r, g, b}, 32'd0);
      chk("rst_addr", mem_addr, 32'h100);
      chk("rst_busy", {31'd0, fetch_busy}, 32'd0);
    end
    reset = 1'b1;
    sb.push_back(model_rgb(x, y, fb_en));
  endtask

  initial begin
    reset = 1'b0;
    x = 10'd0;
    y = 10'd0;
    fb_en = 1'b1;
    for (int w = 0; w < 20; w++) exp_buf[w] = 32'd0;

    // Reset, then outputs stay black before any fetch.
    do_reset();
    pixels(10'd0, 0, 40, 1'b1);

    // Row-0 fetch during the last line of the frame.
    sweep(10'd524, 661, 1'b1, 1'b1, 32'h100);

    // Pixel decode on line 0, including the word-1 boundary at x=32.
    pixels(10'd0, 0, 40, 1'b1);
    pixels(10'd0, 600, 639, 1'b1);

    // Row reuse on lines 0..2, then row 1 fetched on line 3.
    sweep(10'd0, 645, 1'b1, 1'b0, 32'h0);
    sweep(10'd1, 645, 1'b1, 1'b0, 32'h0);
    sweep(10'd2, 645, 1'b1, 1'b0, 32'h0);
    sweep(10'd3, 661, 1'b1, 1'b1, 32'h150);
    pixels(10'd4, 0, 40, 1'b1);

    // Boundaries: no fetch at y=479, black outside the active area.
    sweep(10'd479, 645, 1'b1, 1'b0, 32'h0);
    cyc(10'd100, 10'd480, 1'b1);
    cyc(10'd100, 10'd500, 1'b1);
    cyc(10'd700, 10'd10, 1'b1);
    cyc(10'd639, 10'd479, 1'b1);

    // Display disabled: black and no fetch at y=524.
    pixels(10'd4, 0, 8, 1'b0);
    sweep(10'd524, 661, 1'b0, 1'b0, 32'h0);
    pixels(10'd4, 28, 36, 1'b1);

    // Mid-fetch reset at x=650, buffer reads black, then a clean refetch.
    sweep(10'd524, 650, 1'b1, 1'b1, 32'h100);
    do_reset();
    pixels(10'd0, 0, 40, 1'b1);
    sweep(10'd524, 661, 1'b1, 1'b1, 32'h100);
    pixels(10'd0, 0, 40, 1'b1);
    pixels(10'd0, 620, 639, 1'b1);

    // Flush the last scoreboard entry.
    cyc(10'd700, 10'd0, 1'b1);
    @(posedge clk); #1;
    if (sb.size() > 0) chk("rgb", {8'h00, r, g, b}, {8'h00, sb.pop_front()});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
